spi_cmd_sequencer: RTL and testbench

Command front end for the SPI master engine. Parses host command packets from a byte stream (JTAG data-register side), preloads the engine's TX FIFO, issues one `work` pulse with bit length and direction, and streams received bytes from the RX FIFO back to the host. Each packet ends with one status byte. The block sits directly upstream of the SPI engine's control port and TX FIFO write side, and downstream of its RX FIFO read side.

---
 rtl/spi_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_cmd_sequencer
//
// Command front end for the SPI master engine. It takes host command packets
// from a byte stream and runs one engine transfer per packet:
//   HDR (bit0 = op, bits 7:1 reserved = 0), NB_H, NB_L (byte count N,
//   big-endian), then the payload (N bytes for a write, 3 command/address
//   bytes for a read).
// The payload is copied into the engine TX FIFO. One `work` pulse starts the
// engine with `len` = N*8 bits and `op`. For reads, the N-3 received bytes are
// drained from the RX FIFO to the host. Every packet ends with one status
// byte: 0xA5 = OK, 0xE0 = bad header, 0xE2 = engine never went busy.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   in_data/valid/ready   : host command byte stream (sink)
//   out_data/valid/ready  : host response byte stream (source)
//   tx_wdata, tx_wr       : engine TX FIFO write side
//   tx_full               : engine TX FIFO full
//   rx_rdata, rx_empty    : engine RX FIFO head (first-word-fall-through)
//   rx_rd                 : engine RX FIFO pop
//   len, op, work         : engine control (bit length, direction, start)
//   busy                  : engine busy
// -----------------------------------------------------------------------------
module spi_cmd_sequencer #(
    parameter int TX_DEPTH  = 256,
    parameter int MAX_BYTES = 8191
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  tx_wdata,
    output logic        tx_wr,
    input  logic        tx_full,
    input  logic [7:0]  rx_rdata,
    output logic        rx_rd,
    input  logic        rx_empty,
    output logic [15:0] len,
    output logic        op,
    output logic        work,
    input  logic        busy
);

    localparam logic [7:0] STAT_OK      = 8'hA5;
    localparam logic [7:0] STAT_BAD_HDR = 8'hE0;
    localparam logic [7:0] STAT_NO_BUSY = 8'hE2;

    // Number of cycles after the work pulse in which busy must show up.
    localparam logic [1:0] ARM_LAST = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_NB_H,
        ST_NB_L,
        ST_CHECK,
        ST_LOAD,
        ST_START,
        ST_ARM,
        ST_RUN,
        ST_DRAIN,
        ST_STATUS
    } state_t;

    state_t      state_reg;
    logic [7:0]  hdr_reg;
    logic [15:0] nbytes_reg;
    logic [15:0] load_cnt_reg;   // payload bytes still to copy into the TX FIFO
    logic [15:0] rem_reg;        // RX bytes still to forward to the host
    logic [1:0]  arm_cnt_reg;
    logic [15:0] len_reg;
    logic        op_reg;
    logic        work_reg;
    logic [7:0]  out_data_reg;
    logic        out_valid_reg;

    logic        op_bit;
    logic        in_fire;
    logic        slot_free;
    logic        drain_fire;
    logic        header_bad;

    assign op_bit = hdr_reg[0];

    // -------------------------------------------------------------------------
    // Input handshake. Only the header states and LOAD take bytes; in LOAD the
    // byte goes straight through to the TX FIFO, so acceptance follows tx_full.
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            ST_HDR, ST_NB_H, ST_NB_L: in_ready = 1'b1;
            ST_LOAD:                  in_ready = !tx_full;
            default:                  in_ready = 1'b0;
        endcase
    end

    assign in_fire  = in_valid & in_ready;
    assign tx_wr    = (state_reg == ST_LOAD) & in_fire;
    assign tx_wdata = (state_reg == ST_LOAD) ? in_data : 8'h00;

    // -------------------------------------------------------------------------
    // RX drain. The output register is a one-deep slot: it can take a new byte
    // when empty or when its current byte leaves this cycle. The pop is
    // combinational so the FIFO head is consumed in the same cycle the byte is
    // captured, giving exactly one pop per forwarded byte.
    // -------------------------------------------------------------------------
    assign slot_free  = !out_valid_reg | out_ready;
    assign drain_fire = ((state_reg == ST_RUN) || (state_reg == ST_DRAIN)) &&
                        (rem_reg != 16'd0) && !rx_empty && slot_free;
    assign rx_rd      = drain_fire;

    // -------------------------------------------------------------------------
    // Header validation, evaluated in CHECK from the captured header.
    // len = N*8 must fit 16 bits, hence the MAX_BYTES bound. A read needs the
    // 3 command/address bytes plus at least one byte to receive.
    // -------------------------------------------------------------------------
    always_comb begin
        header_bad = 1'b0;
        if (hdr_reg[7:1] != 7'd0)
            header_bad = 1'b1;
        if (nbytes_reg == 16'd0)
            header_bad = 1'b1;
        if (nbytes_reg > 16'(MAX_BYTES))
            header_bad = 1'b1;
        if (op_bit && (nbytes_reg > 16'(TX_DEPTH)))
            header_bad = 1'b1;
        if (!op_bit && (nbytes_reg < 16'd4))
            header_bad = 1'b1;
    end

    // -------------------------------------------------------------------------
    // Main sequencer.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            hdr_reg       <= 8'h00;
            nbytes_reg    <= 16'd0;
            load_cnt_reg  <= 16'd0;
            rem_reg       <= 16'd0;
            arm_cnt_reg   <= 2'd0;
            len_reg       <= 16'd0;
            op_reg        <= 1'b0;
            work_reg      <= 1'b0;
            out_data_reg  <= 8'h00;
            out_valid_reg <= 1'b0;
        end else begin
            work_reg <= 1'b0;

            // Output slot: retire an accepted byte, then refill from the RX
            // FIFO if a drain happens this cycle. State-specific status loads
            // below take precedence; they only occur when no drain is possible.
            if (out_valid_reg && out_ready)
                out_valid_reg <= 1'b0;
            if (drain_fire) begin
                out_data_reg  <= rx_rdata;
                out_valid_reg <= 1'b1;
                rem_reg       <= rem_reg - 16'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_HDR;
                end

                ST_HDR: begin
                    if (in_fire) begin
                        hdr_reg   <= in_data;
                        state_reg <= ST_NB_H;
                    end
                end

                ST_NB_H: begin
                    if (in_fire) begin
                        nbytes_reg[15:8] <= in_data;
                        state_reg        <= ST_NB_L;
                    end
                end

                ST_NB_L: begin
                    if (in_fire) begin
                        nbytes_reg[7:0] <= in_data;
                        state_reg       <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (header_bad) begin
                        out_data_reg  <= STAT_BAD_HDR;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_STATUS;
                    end else begin
                        load_cnt_reg <= op_bit ? nbytes_reg : 16'd3;
                        rem_reg      <= op_bit ? 16'd0 : (nbytes_reg - 16'd3);
                        state_reg    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (in_fire) begin
                        load_cnt_reg <= load_cnt_reg - 16'd1;
                        if (load_cnt_reg == 16'd1) begin
                            // Engine controls are registered here so that they
                            // are valid together with work during START, the
                            // cycle right after the last TX write.
                            len_reg   <= {nbytes_reg[12:0], 3'b000};
                            op_reg    <= op_bit;
                            work_reg  <= 1'b1;
                            state_reg <= ST_START;
                        end
                    end
                end

                ST_START: begin
                    arm_cnt_reg <= 2'd0;
                    state_reg   <= ST_ARM;
                end

                ST_ARM: begin
                    // busy is sampled in each of the four cycles after work.
                    if (busy) begin
                        state_reg <= ST_RUN;
                    end else if (arm_cnt_reg == ARM_LAST) begin
                        out_data_reg  <= STAT_NO_BUSY;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_STATUS;
                    end else begin
                        arm_cnt_reg <= arm_cnt_reg + 2'd1;
                    end
                end

                ST_RUN: begin
                    if (!busy)
                        state_reg <= ST_DRAIN;
                end

                ST_DRAIN: begin
                    // rem_reg == 0 excludes drain_fire, so the status byte can
                    // own the slot as soon as the last data byte leaves.
                    if ((rem_reg == 16'd0) && slot_free) begin
                        out_data_reg  <= STAT_OK;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_STATUS;
                    end
                end

                ST_STATUS: begin
                    if (out_ready)
                        state_reg <= ST_HDR;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign len       = len_reg;
    assign op        = op_reg;
    assign work      = work_reg;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_sequencer
//
// Directed packets with hand-computed expectations. Stimulus pushes the
// expected host bytes, TX FIFO writes and engine starts into queues; monitor
// processes pop and compare whenever the DUT presents them. A small engine
// model raises busy one cycle after work, fills the RX FIFO model and drops
// busy after a programmable time.
// -----------------------------------------------------------------------------
module tb_spi_cmd_sequencer;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  tx_wdata;
    logic        tx_wr;
    logic        tx_full = 1'b0;
    logic [7:0]  rx_rdata;
    logic        rx_rd;
    logic        rx_empty;
    logic [15:0] len;
    logic        op;
    logic        work;
    logic        busy;

    always #5 clk = ~clk;

    spi_cmd_sequencer #(
        .TX_DEPTH  (256),
        .MAX_BYTES (8191)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tx_wdata  (tx_wdata),
        .tx_wr     (tx_wr),
        .tx_full   (tx_full),
        .rx_rdata  (rx_rdata),
        .rx_rd     (rx_rd),
        .rx_empty  (rx_empty),
        .len       (len),
        .op        (op),
        .work      (work),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues and event counters.
    logic [7:0]  exp_out[$];
    logic [7:0]  exp_tx[$];
    logic [16:0] exp_work[$];   // {len, op}
    int tx_cnt = 0, work_cnt = 0, rd_cnt = 0;
    int work_cyc = 0, last_tx_cyc = 0;

    // Engine model configuration (written by stimulus only).
    logic       engine_dead = 1'b0;
    int         busy_len    = 6;
    logic [7:0] eng_rx[0:7];
    int         eng_rx_n    = 0;
    logic       bp_mode     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // ---------------- output monitor ----------------
    logic [7:0] mon_exp;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_extra: got %02h want no byte", out_data);
            end else begin
                mon_exp = exp_out.pop_front();
                $display("[%0d] out %02h (want %02h)", cyc, out_data, mon_exp);
                check("out_byte", {24'd0, out_data}, {24'd0, mon_exp});
            end
        end
    end

    // ---------------- output stability during stalls ----------------
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("out_valid_hold", {31'd0, out_valid}, 32'd1);
                check("out_data_hold", {24'd0, out_data}, {24'd0, stall_data});
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    // ---------------- TX FIFO write monitor ----------------
    logic [7:0] tx_exp;
    always @(negedge clk) begin
        if (!rst && tx_wr) begin
            tx_cnt++;
            last_tx_cyc = cyc;
            if (exp_tx.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_extra: got %02h want no write", tx_wdata);
            end else begin
                tx_exp = exp_tx.pop_front();
                $display("[%0d] tx_wr %02h (want %02h)", cyc, tx_wdata, tx_exp);
                check("tx_wdata", {24'd0, tx_wdata}, {24'd0, tx_exp});
            end
        end
    end

    // ---------------- engine start monitor ----------------
    logic [16:0] w_exp;
    always @(negedge clk) begin
        if (!rst && work) begin
            work_cnt++;
            work_cyc = cyc;
            if (exp_work.size() == 0) begin
                total++;
                bad++;
                $display("FAIL work_extra: got len=%04h op=%0d want no pulse", len, op);
            end else begin
                w_exp = exp_work.pop_front();
                $display("[%0d] work len=%04h op=%0d", cyc, len, op);
                check("work_len", {16'd0, len}, {16'd0, w_exp[16:1]});
                check("work_op", {31'd0, op}, {31'd0, w_exp[0]});
                check("work_after_last_wr", cyc - last_tx_cyc, 32'd1);
            end
        end
        if (!rst && rx_rd)
            rd_cnt++;
    end

    // ---------------- engine + RX FIFO model ----------------
    logic [7:0] rx_q[$];
    initial begin
        logic s_pop, s_work, s_rst;
        int   busy_cnt;
        busy     = 1'b0;
        rx_empty = 1'b1;
        rx_rdata = 8'h00;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            s_pop  = rx_rd;
            s_work = work;
            s_rst  = rst;
            @(posedge clk);
            #1;
            if (s_rst) begin
                busy     = 1'b0;
                busy_cnt = 0;
                rx_q.delete();
            end else begin
                if (s_pop && rx_q.size() > 0)
                    void'(rx_q.pop_front());
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0)
                        busy = 1'b0;
                end
                if (s_work && !engine_dead) begin
                    busy     = 1'b1;
                    busy_cnt = busy_len;
                    for (int i = 0; i < eng_rx_n; i++)
                        rx_q.push_back(eng_rx[i]);
                end
            end
            rx_empty = (rx_q.size() == 0);
            rx_rdata = rx_empty ? 8'h00 : rx_q[0];
        end
    end

    // ---------------- host out_ready driver ----------------
    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;   // 1,0,0,1 read from bit 3 down
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = pat[3 - k];
                k = (k + 1) % 4;
            end else begin
                out_ready = 1'b1;
                k = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout: byte %02h not accepted, want accepted", b);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t q);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_out.size() == 0 && !out_valid) break;
            n++;
            if (n > 300) begin
                total++;
                bad++;
                $display("FAIL %s: timeout with %0d bytes pending, want 0", name, exp_out.size());
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        $display("[%0d] reset check %s", cyc, tag);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_data"},  {24'd0, out_data},  32'd0);
        check({tag, "_tx_wr"},     {31'd0, tx_wr},     32'd0);
        check({tag, "_tx_wdata"},  {24'd0, tx_wdata},  32'd0);
        check({tag, "_rx_rd"},     {31'd0, rx_rd},     32'd0);
        check({tag, "_len"},       {16'd0, len},       32'd0);
        check({tag, "_op"},        {31'd0, op},        32'd0);
        check({tag, "_work"},      {31'd0, work},      32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        byte_q_t pk;
        int tx0, wk0, rd0, n;
        byte_q_t hdrs;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write: 4 bytes, len = 32 bits
        tx0 = tx_cnt; wk0 = work_cnt; rd0 = rd_cnt;
        eng_rx_n = 0;
        exp_tx.push_back(8'hDE); exp_tx.push_back(8'hAD);
        exp_tx.push_back(8'hBE); exp_tx.push_back(8'hEF);
        exp_work.push_back({16'h0020, 1'b1});
        exp_out.push_back(8'hA5);
        pk = '{8'h01, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_bytes(pk);
        wait_done("write");
        check("write_tx_count", tx_cnt - tx0, 32'd4);
        check("write_work_count", work_cnt - wk0, 32'd1);
        check("write_rd_count", rd_cnt - rd0, 32'd0);

        // Read: N=6 -> 3 command bytes out, 3 data bytes back, len = 48 bits
        eng_rx[0] = 8'h11; eng_rx[1] = 8'h22; eng_rx[2] = 8'h33;
        eng_rx_n  = 3;
        for (int pass = 0; pass < 2; pass++) begin
            bp_mode = (pass == 1);
            tx0 = tx_cnt; wk0 = work_cnt; rd0 = rd_cnt;
            exp_tx.push_back(8'h03); exp_tx.push_back(8'h00); exp_tx.push_back(8'h10);
            exp_work.push_back({16'h0030, 1'b0});
            exp_out.push_back(8'h11); exp_out.push_back(8'h22);
            exp_out.push_back(8'h33); exp_out.push_back(8'hA5);
            pk = '{8'h00, 8'h00, 8'h06, 8'h03, 8'h00, 8'h10};
            send_bytes(pk);
            wait_done(pass == 0 ? "read" : "read_bp");
            check("read_tx_count", tx_cnt - tx0, 32'd3);
            check("read_work_count", work_cnt - wk0, 32'd1);
            check("read_rd_count", rd_cnt - rd0, 32'd3);
        end
        bp_mode  = 1'b0;
        eng_rx_n = 0;

        // TX FIFO full for 5 cycles in the middle of the payload
        tx0 = tx_cnt; wk0 = work_cnt;
        exp_tx.push_back(8'h10); exp_tx.push_back(8'h20);
        exp_tx.push_back(8'h30); exp_tx.push_back(8'h40);
        exp_work.push_back({16'h0020, 1'b1});
        exp_out.push_back(8'hA5);
        pk = '{8'h01, 8'h00, 8'h04, 8'h10, 8'h20};
        send_bytes(pk);
        tx_full  = 1'b1;
        in_data  = 8'h30;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("txfull_in_ready", {31'd0, in_ready}, 32'd0);
            check("txfull_tx_wr", {31'd0, tx_wr}, 32'd0);
            @(posedge clk);
            #1;
        end
        tx_full = 1'b0;
        send_byte(8'h30);
        send_byte(8'h40);
        wait_done("txfull");
        check("txfull_tx_count", tx_cnt - tx0, 32'd4);
        check("txfull_work_count", work_cnt - wk0, 32'd1);

        // Header errors: reserved bit, N=0, read with N<4, write with N>TX_DEPTH
        hdrs = '{8'h02, 8'h00, 8'h04,
                 8'h01, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h03,
                 8'h01, 8'h01, 8'h01};
        for (int e = 0; e < 4; e++) begin
            tx0 = tx_cnt; wk0 = work_cnt;
            exp_out.push_back(8'hE0);
            pk = '{hdrs[3*e], hdrs[3*e+1], hdrs[3*e+2]};
            send_bytes(pk);
            wait_done("hdr_err");
            check("err_tx_count", tx_cnt - tx0, 32'd0);
            check("err_work_count", work_cnt - wk0, 32'd0);
        end

        // Valid packet after the errors
        exp_tx.push_back(8'h77);
        exp_work.push_back({16'h0008, 1'b1});
        exp_out.push_back(8'hA5);
        pk = '{8'h01, 8'h00, 8'h01, 8'h77};
        send_bytes(pk);
        wait_done("after_err");

        // Engine dead: busy never rises -> E2. busy is watched in the four
        // cycles after work; the status register loads one cycle later.
        engine_dead = 1'b1;
        exp_tx.push_back(8'h5A);
        exp_work.push_back({16'h0008, 1'b1});
        exp_out.push_back(8'hE2);
        pk = '{8'h01, 8'h00, 8'h01, 8'h5A};
        send_bytes(pk);
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL dead_status_timeout: no status byte, want E2");
                break;
            end
        end
        check("dead_latency", cyc - work_cyc, 32'd5);
        wait_done("dead");
        engine_dead = 1'b0;

        // Reset while the engine is running a long write
        busy_len = 30;
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h02);
        exp_work.push_back({16'h0010, 1'b1});
        pk = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h02};
        send_bytes(pk);
        n = 0;
        forever begin
            @(negedge clk);
            if (busy) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL run_busy_timeout: busy not seen, want 1");
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("mid_run");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        busy_len = 6;

        // Fresh packet after the reset
        tx0 = tx_cnt; wk0 = work_cnt;
        exp_tx.push_back(8'h33);
        exp_work.push_back({16'h0008, 1'b1});
        exp_out.push_back(8'hA5);
        pk = '{8'h01, 8'h00, 8'h01, 8'h33};
        send_bytes(pk);
        wait_done("post_rst");
        check("post_rst_tx_count", tx_cnt - tx0, 32'd1);
        check("post_rst_work_count", work_cnt - wk0, 32'd1);

        check("tx_queue_left", exp_tx.size(), 32'd0);
        check("work_queue_left", exp_work.size(), 32'd0);
        check("out_queue_left", exp_out.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
